// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with single-cycle logic/arith ops and shift-add MULTU
//
// Purpose: accepts one operation per start pulse while idle. AND/OR/NOR/ADD/SUB/SLT and
// unsupported codes complete after one cycle. MULTU runs one multiplier bit per cycle
// for WIDTH cycles. All result flags are registered and held until the next completion.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - operation request, sampled only in IDLE
//   ctl     - function code (36 AND, 37 OR, 39 NOR, 32 ADD, 34 SUB, 42 SLT, 25 MULTU)
//   a, b    - operands
//   busy    - high while not IDLE
//   done    - one-cycle completion pulse
//   result  - low result word
//   hi      - upper product word for MULTU, zero otherwise
//   zero    - result == 0
//   ovf     - signed overflow (ADD/SUB only)
//   illegal - unsupported function code
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_NOR   = 6'd39;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_MULTU = 6'd25;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             carry_into_msb;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

  // Shift-add step: multiplier sits in the low half of prod and is consumed LSB first.
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] prod_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (ctl == OP_MULTU) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    is_sub         = (ctl == OP_SUB) || (ctl == OP_SLT);
    b_op           = is_sub ? ~b : b;
    sum            = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    carry_into_msb = a[WIDTH-1] ^ b_op[WIDTH-1] ^ sum[WIDTH-1];
    add_ovf        = carry_into_msb ^ sum[WIDTH];

    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ctl)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_ovf = add_ovf;
      end
      // Signed less-than: sign of the difference corrected by its overflow.
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      OP_MULTU: alu_res = '0;
      default:  alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    mul_add   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    prod_next = {mul_add, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      prod    <= '0;
      cnt     <= '0;
      result  <= '0;
      hi      <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q  <= a;
            prod <= {{WIDTH{1'b0}}, b};
            cnt  <= '0;
            if (ctl != OP_MULTU) begin
              result  <= alu_res;
              hi      <= '0;
              zero    <= (alu_res == '0);
              ovf     <= alu_ovf;
              illegal <= alu_ill;
            end
          end
        end
        S_MUL: begin
          prod <= prod_next;
          cnt  <= cnt + CW'(1);
          // The final iteration and the DONE entry share one edge, so the
          // outputs are loaded from the combinational next product.
          if (cnt == CNT_LAST) begin
            result  <= prod_next[WIDTH-1:0];
            hi      <= prod_next[2*WIDTH-1:WIDTH];
            zero    <= (prod_next[WIDTH-1:0] == '0);
            ovf     <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
